// File: rtl/pe_act_vec_unit_if.sv
// rtl/pe_act_vec_unit_if.sv - config, start, activation, output and done handshakes of pe_act_vec_unit
interface pe_act_vec_unit_if #(
    parameter int LANES = 16,
    parameter int WIDTH = 20
);
    logic                     cfg_val;
    logic                     cfg_rdy;
    logic [4:0]               cfg_addr;
    logic [15:0]              cfg_data;
    logic                     start_val;
    logic                     start_rdy;
    logic [LANES*WIDTH-1:0]   act_port_msg;
    logic                     act_port_val;
    logic                     act_port_rdy;
    logic [LANES*WIDTH-1:0]   output_port_msg;
    logic                     output_port_val;
    logic                     output_port_rdy;
    logic                     done_msg;
    logic                     done_val;
    logic                     done_rdy;

    modport master (
        output cfg_val, cfg_addr, cfg_data, start_val, act_port_msg, act_port_val,
               output_port_rdy, done_rdy,
        input  cfg_rdy, start_rdy, act_port_rdy, output_port_msg, output_port_val,
               done_msg, done_val
    );

    modport slave (
        input  cfg_val, cfg_addr, cfg_data, start_val, act_port_msg, act_port_val,
               output_port_rdy, done_rdy,
        output cfg_rdy, start_rdy, act_port_rdy, output_port_msg, output_port_val,
               done_msg, done_val
    );
endinterface

// File: rtl/pe_act_vec_unit.sv
// rtl/pe_act_vec_unit.sv - programmable LANES-wide fixed-point activation vector engine
module pe_act_vec_unit #(
    parameter int LANES = 16,
    parameter int WIDTH = 20,
    parameter int FRAC  = 14,
    parameter int NREG  = 4,
    parameter int NINST = 8
) (
    input  logic              clk,
    input  logic              rst,
    pe_act_vec_unit_if.slave  bus
);
    localparam int VW = LANES * WIDTH;
    localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int IW = (NINST > 1) ? $clog2(NINST) : 1;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_EXEC     = 3'd1;
    localparam logic [2:0] S_WAIT_IN  = 3'd2;
    localparam logic [2:0] S_WAIT_OUT = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    localparam logic [3:0] OP_INPE  = 4'd1;
    localparam logic [3:0] OP_OUTP  = 4'd2;
    localparam logic [3:0] OP_RELU  = 4'd3;
    localparam logic [3:0] OP_ADD   = 4'd4;
    localparam logic [3:0] OP_EMUL  = 4'd5;
    localparam logic [3:0] OP_ONEX  = 4'd6;
    localparam logic [3:0] OP_HTANH = 4'd7;

    localparam logic signed [2*WIDTH-1:0] SMAX    = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [2*WIDTH-1:0] SMIN    = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic signed [2*WIDTH-1:0] ONE     = {{(2*WIDTH-1){1'b0}}, 1'b1} << FRAC;
    localparam logic signed [2*WIDTH-1:0] NEG_ONE = -ONE;

    logic [2:0]    state;
    logic [7:0]    slot [NINST];
    logic [3:0]    num_inst;
    logic [7:0]    num_loop;
    logic [3:0]    pc;
    logic [7:0]    loop_cnt;
    logic [VW-1:0] regs [1<<RW];
    logic [VW-1:0] out_msg;
    logic [VW-1:0] alu_res;

    logic [7:0]    inst;
    logic [3:0]    op;
    logic [RW-1:0] ra;
    logic [RW-1:0] rb;
    logic          is_alu;
    logic [3:0]    nxt_pc;
    logic [7:0]    nxt_loop;
    logic [2:0]    nxt_state;
    logic          unused_cfg;

    assign inst   = slot[pc[IW-1:0]];
    assign op     = inst[7:4];
    assign ra     = inst[2 +: RW];
    assign rb     = inst[0 +: RW];
    assign is_alu = (op >= OP_RELU) && (op <= OP_HTANH);
    assign unused_cfg = ^bus.cfg_data[15:12];

    function automatic logic signed [WIDTH-1:0] sat(input logic signed [2*WIDTH-1:0] v);
        if (v > SMAX)
            sat = SMAX[WIDTH-1:0];
        else if (v < SMIN)
            sat = SMIN[WIDTH-1:0];
        else
            sat = v[WIDTH-1:0];
    endfunction

    // Lanes are widened to 2*WIDTH so add, 1-x and the full product never wrap before saturation.
    always_comb begin
        logic signed [WIDTH-1:0]   a;
        logic signed [WIDTH-1:0]   b;
        logic signed [WIDTH-1:0]   r;
        logic signed [2*WIDTH-1:0] ax;
        logic signed [2*WIDTH-1:0] bx;
        alu_res = '0;
        for (int i = 0; i < LANES; i++) begin
            a  = regs[ra][i*WIDTH +: WIDTH];
            b  = regs[rb][i*WIDTH +: WIDTH];
            ax = a;
            bx = b;
            case (op)
                OP_RELU:  r = a[WIDTH-1] ? '0 : a;
                OP_ADD:   r = sat(ax + bx);
                OP_EMUL:  r = sat((ax * bx) >>> FRAC);
                OP_ONEX:  r = sat(ONE - ax);
                OP_HTANH: r = sat((ax > ONE) ? ONE : ((ax < NEG_ONE) ? NEG_ONE : ax));
                default:  r = a;
            endcase
            alu_res[i*WIDTH +: WIDTH] = r;
        end
    end

    // Where the sequencer goes once the instruction at pc has completed.
    always_comb begin
        nxt_pc    = pc + 4'd1;
        nxt_loop  = loop_cnt;
        nxt_state = S_EXEC;
        if (pc == num_inst - 4'd1) begin
            nxt_pc   = '0;
            nxt_loop = loop_cnt + 8'd1;
            if (loop_cnt + 8'd1 == num_loop)
                nxt_state = S_DONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            num_inst <= '0;
            num_loop <= '0;
            pc       <= '0;
            loop_cnt <= '0;
            out_msg  <= '0;
            for (int i = 0; i < NINST; i++)
                slot[i] <= '0;
            for (int i = 0; i < (1 << RW); i++)
                regs[i] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.cfg_val) begin
                        if (bus.cfg_addr < 5'(NINST))
                            slot[bus.cfg_addr[IW-1:0]] <= bus.cfg_data[7:0];
                        else if (bus.cfg_addr == 5'd16) begin
                            num_inst <= bus.cfg_data[11:8];
                            num_loop <= bus.cfg_data[7:0];
                        end
                    end
                    if (bus.start_val) begin
                        pc       <= '0;
                        loop_cnt <= '0;
                        state    <= (num_inst == 4'd0 || num_loop == 8'd0) ? S_DONE : S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (op == OP_INPE)
                        state <= S_WAIT_IN;
                    else if (op == OP_OUTP) begin
                        out_msg <= regs[ra];
                        state   <= S_WAIT_OUT;
                    end else begin
                        if (is_alu)
                            regs[ra] <= alu_res;
                        pc       <= nxt_pc;
                        loop_cnt <= nxt_loop;
                        state    <= nxt_state;
                    end
                end
                S_WAIT_IN: begin
                    if (bus.act_port_val) begin
                        regs[ra] <= bus.act_port_msg;
                        pc       <= nxt_pc;
                        loop_cnt <= nxt_loop;
                        state    <= nxt_state;
                    end
                end
                S_WAIT_OUT: begin
                    if (bus.output_port_rdy) begin
                        pc       <= nxt_pc;
                        loop_cnt <= nxt_loop;
                        state    <= nxt_state;
                    end
                end
                S_DONE: begin
                    if (bus.done_rdy)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Handshake outputs decode straight from state so reset drops them without waiting for a clock.
    assign bus.cfg_rdy         = (state == S_IDLE);
    assign bus.start_rdy       = (state == S_IDLE);
    assign bus.act_port_rdy    = (state == S_WAIT_IN);
    assign bus.output_port_val = (state == S_WAIT_OUT);
    assign bus.output_port_msg = out_msg;
    assign bus.done_val        = (state == S_DONE);
    assign bus.done_msg        = 1'b1;
endmodule

// File: tb/tb_pe_act_vec_unit.sv
// tb/tb_pe_act_vec_unit.sv - scoreboard bench for pe_act_vec_unit
module tb_pe_act_vec_unit;
    localparam int LANES = 16;
    localparam int WIDTH = 20;
    localparam int VW    = LANES * WIDTH;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pe_act_vec_unit_if #(.LANES(LANES), .WIDTH(WIDTH)) bus ();
    pe_act_vec_unit #(.LANES(LANES), .WIDTH(WIDTH), .FRAC(14), .NREG(4), .NINST(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int            n_chk = 0;
    int            n_pass = 0;
    int            dones = 0;
    logic [VW-1:0] exp_q [$];
    logic          done_q [$];
    bit            rnd_en = 1'b0;
    logic          rdy_fix = 1'b1;

    task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [VW-1:0] rep(input logic [WIDTH-1:0] v);
        logic [VW-1:0] r;
        for (int i = 0; i < LANES; i++)
            r[i*WIDTH +: WIDTH] = v;
        return r;
    endfunction

    function automatic logic [VW-1:0] mkv(input int k);
        logic [VW-1:0] r;
        for (int i = 0; i < LANES; i++)
            r[i*WIDTH +: WIDTH] = 20'(k * 256 + i);
        return r;
    endfunction

    initial begin
        bus.output_port_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.output_port_rdy = rnd_en ? 1'($urandom_range(0, 1)) : rdy_fix;
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (bus.output_port_val) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL out_unexpected: got %h expected no output", bus.output_port_msg);
                end else begin
                    chk("out_msg", bus.output_port_msg, exp_q[0]);
                    if (bus.output_port_rdy)
                        void'(exp_q.pop_front());
                end
            end
            if (bus.done_val && bus.done_rdy) begin
                dones++;
                if (done_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL done_unexpected: got token expected none");
                end else
                    chk("done_msg", VW'(bus.done_msg), VW'(done_q.pop_front()));
            end
        end
    end

    task automatic cfg_wr(input logic [4:0] addr, input logic [15:0] data);
        @(posedge clk); #1;
        bus.cfg_val = 1'b1; bus.cfg_addr = addr; bus.cfg_data = data;
        @(posedge clk); #1;
        bus.cfg_val = 1'b0;
    endtask

    task automatic prog(input logic [63:0] words, input int ni, input int nl);
        for (int j = 0; j < ni; j++)
            cfg_wr(5'(j), {8'h00, words[j*8 +: 8]});
        cfg_wr(5'd16, {4'h0, 4'(ni), 8'(nl)});
    endtask

    task automatic do_start();
        @(posedge clk); #1;
        bus.start_val = 1'b1;
        @(posedge clk); #1;
        bus.start_val = 1'b0;
        done_q.push_back(1'b1);
    endtask

    task automatic send_act(input logic [VW-1:0] v);
        int c = 0;
        @(posedge clk); #1;
        bus.act_port_val = 1'b1; bus.act_port_msg = v;
        do begin
            @(negedge clk);
            c++;
        end while (!bus.act_port_rdy && c < 500);
        if (!bus.act_port_rdy) begin
            n_chk++;
            $display("FAIL act_timeout: got act_port_rdy 0 expected 1");
        end
        @(posedge clk); #1;
        bus.act_port_val = 1'b0;
    endtask

    task automatic wait_dones(input int n);
        int c = 0;
        while (dones < n && c < 2000) begin
            @(negedge clk);
            c++;
        end
        if (dones < n) begin
            n_chk++;
            $display("FAIL wait_done: got %0d tokens expected %0d", dones, n);
        end
    endtask

    initial begin
        int c;
        rst = 1'b1;
        bus.cfg_val = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
        bus.start_val = 1'b0; bus.act_port_val = 1'b0; bus.act_port_msg = '0;
        bus.done_rdy = 1'b1;
        #12;
        chk("rst_out_msg", bus.output_port_msg, '0);
        chk("rst_out_val", VW'(bus.output_port_val), '0);
        chk("rst_act_rdy", VW'(bus.act_port_rdy), '0);
        chk("rst_done_val", VW'(bus.done_val), '0);
        chk("rst_done_msg", VW'(bus.done_msg), VW'(1));
        chk("rst_start_rdy", VW'(bus.start_rdy), VW'(1));
        chk("rst_cfg_rdy", VW'(bus.cfg_rdy), VW'(1));
        @(posedge clk); #1;
        rst = 1'b0;

        // unmapped config address is accepted
        @(posedge clk); #1;
        bus.cfg_val = 1'b1; bus.cfg_addr = 5'd20; bus.cfg_data = 16'hFFFF;
        @(negedge clk);
        chk("cfg_rdy_unmapped", VW'(bus.cfg_rdy), VW'(1));
        @(posedge clk); #1;
        bus.cfg_val = 1'b0;

        // INPE r0, OUTP r0
        prog({48'h0, 8'h20, 8'h10}, 2, 1);
        exp_q.push_back(rep(20'h01234));
        do_start();
        send_act(rep(20'h01234));
        wait_dones(1);

        // INPE r0, INPE r1, EMUL r0 r1, OUTP r0
        prog({32'h0, 8'h20, 8'h51, 8'h14, 8'h10}, 4, 1);
        exp_q.push_back(rep(20'hFE000));
        do_start();
        send_act(rep(20'h04000));
        send_act(rep(20'hFE000));
        wait_dones(2);
        exp_q.push_back(rep(20'h7FFFF));
        do_start();
        send_act(rep(20'h7FFFF));
        send_act(rep(20'h7FFFF));
        wait_dones(3);

        // ADD with negative saturation
        prog({32'h0, 8'h20, 8'h41, 8'h14, 8'h10}, 4, 1);
        exp_q.push_back(rep(20'h80000));
        do_start();
        send_act(rep(20'hA0000));
        send_act(rep(20'hA0000));
        wait_dones(4);

        // INPE r0, ONEX r0, OUTP r0, RELU r0, OUTP r0
        prog({24'h0, 8'h20, 8'h30, 8'h20, 8'h60, 8'h10}, 5, 1);
        exp_q.push_back(rep(20'hFE000));
        exp_q.push_back(rep(20'h00000));
        do_start();
        send_act(rep(20'h06000));
        wait_dones(5);

        // INPE r0, HTANH r0, OUTP r0
        prog({40'h0, 8'h20, 8'h70, 8'h10}, 3, 1);
        exp_q.push_back(rep(20'hFC000));
        do_start();
        send_act(rep(20'hF63C0));
        wait_dones(6);

        // three loops; first pass stalls the output randomly and tries a config write mid-run
        prog({48'h0, 8'h20, 8'h10}, 2, 3);
        for (int pass = 0; pass < 2; pass++) begin
            rnd_en = (pass == 0);
            for (int k = 0; k < 3; k++)
                exp_q.push_back(mkv(pass * 3 + k + 1));
            do_start();
            if (pass == 0) begin
                @(posedge clk); #1;
                bus.cfg_val = 1'b1; bus.cfg_addr = 5'd16; bus.cfg_data = 16'h0000;
                @(negedge clk);
                chk("cfg_rdy_busy", VW'(bus.cfg_rdy), '0);
                chk("start_rdy_busy", VW'(bus.start_rdy), '0);
                @(posedge clk); #1;
                bus.cfg_val = 1'b0;
            end
            for (int k = 0; k < 3; k++)
                send_act(mkv(pass * 3 + k + 1));
            wait_dones(7 + pass);
        end
        rnd_en = 1'b0;

        // num_loop = 0 finishes immediately
        cfg_wr(5'd16, {4'h0, 4'd2, 8'd0});
        do_start();
        @(negedge clk);
        chk("loop0_done_val", VW'(bus.done_val), VW'(1));
        chk("loop0_act_rdy", VW'(bus.act_port_rdy), '0);
        chk("loop0_out_val", VW'(bus.output_port_val), '0);
        wait_dones(9);

        // reset while an output is stalled
        prog({48'h0, 8'h20, 8'h10}, 2, 1);
        rdy_fix = 1'b0;
        exp_q.push_back(rep(20'h00ABC));
        do_start();
        send_act(rep(20'h00ABC));
        c = 0;
        while (!bus.output_port_val && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk("stall_out_val", VW'(bus.output_port_val), VW'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_out_val", VW'(bus.output_port_val), '0);
        chk("rst_mid_cfg_rdy", VW'(bus.cfg_rdy), VW'(1));
        chk("rst_mid_start_rdy", VW'(bus.start_rdy), VW'(1));
        chk("rst_mid_out_msg", bus.output_port_msg, '0);
        exp_q.delete();
        done_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        rdy_fix = 1'b1;
        do_start();
        @(negedge clk);
        chk("post_rst_done_val", VW'(bus.done_val), VW'(1));
        wait_dones(10);

        @(negedge clk);
        chk("scoreboard_empty", VW'(exp_q.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
